// File: rtl/multicycle_control.sv
// multicycle_control
//   Multi-cycle control FSM for the didactic RV32I core. Walks the shared
//   datapath (PC, IR, register file, ALU, unified memory port) through
//   FETCH -> DECODE -> EXECUTE -> [MEM] -> [WB] one instruction at a time
//   and drives the ALU op code and operand selects.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high; forces every output inactive
//   instr      IR contents (valid from DECODE onward)
//   alu_zero   ALU zero flag (BEQ/BNE outcome)
//   alu_lsb    ALU result[0] (SLT/SLTU outcome)
//   mem_ready  access completes in the cycle mem_req && mem_ready
//   mem_req    memory access request
//   mem_we     1=store, 0=read
//   addr_sel   memory address: 0=PC, 1=alu_out register
//   ir_we      load IR from memory read data
//   mdr_we     load MDR from memory read data
//   pc_we      update PC
//   pc_src     0=PC+4, 1=alu_out register, 2=ALU result & ~1
//   aout_we    latch ALU result into alu_out register
//   alu_op     ALU op code
//   alu_src_a  0=rs1, 1=PC, 2=zero
//   alu_src_b  0=rs2, 1=immediate
//   rf_we      register-file write enable
//   wb_sel     0=alu_out, 1=MDR, 2=PC+4
//   trap       sticky: illegal/ECALL/EBREAK seen, core halted
module multicycle_control (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        alu_zero,
  input  logic        alu_lsb,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        addr_sel,
  output logic        ir_we,
  output logic        mdr_we,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic        aout_we,
  output logic [3:0]  alu_op,
  output logic [1:0]  alu_src_a,
  output logic        alu_src_b,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic        trap
);

  // ALU op codes shared with the datapath ALU
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;
  localparam logic [3:0] ALU_NOP  = 4'd15;

  // RV32I major opcodes
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [2:0] {
    FETCH   = 3'd0,
    DECODE  = 3'd1,
    EXECUTE = 3'd2,
    MEM     = 3'd3,
    WB      = 3'd4,
    TRAP    = 3'd5
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       is_load;
  logic       is_store;
  logic       opc_legal;
  logic [3:0] arith_op;
  logic [3:0] branch_op;
  logic       branch_ok;
  logic       branch_taken;

  assign opcode   = instr[6:0];
  assign funct3   = instr[14:12];
  assign funct7_5 = instr[30];
  assign is_load  = (opcode == OPC_LOAD);
  assign is_store = (opcode == OPC_STORE);

  // SYSTEM (ECALL/EBREAK/CSR) is deliberately absent: it halts the core.
  always_comb begin
    case (opcode)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
      OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP: opc_legal = 1'b1;
      default:                                opc_legal = 1'b0;
    endcase
  end

  // Register/immediate arithmetic. SUB only exists in register form;
  // shift-right arithmetic is selected by funct7[5] in both forms.
  always_comb begin
    arith_op = ALU_NOP;
    case (funct3)
      3'b000:  arith_op = (opcode == OPC_OP && funct7_5) ? ALU_SUB : ALU_ADD;
      3'b001:  arith_op = ALU_SLL;
      3'b010:  arith_op = ALU_SLT;
      3'b011:  arith_op = ALU_SLTU;
      3'b100:  arith_op = ALU_XOR;
      3'b101:  arith_op = funct7_5 ? ALU_SRA : ALU_SRL;
      3'b110:  arith_op = ALU_OR;
      default: arith_op = ALU_AND;
    endcase
  end

  // Branch compare: funct3[0] inverts the sense (BNE/BGE/BGEU).
  always_comb begin
    branch_op    = ALU_NOP;
    branch_ok    = 1'b1;
    branch_taken = 1'b0;
    case (funct3)
      3'b000, 3'b001: begin
        branch_op    = ALU_SUB;
        branch_taken = alu_zero ^ funct3[0];
      end
      3'b100, 3'b101: begin
        branch_op    = ALU_SLT;
        branch_taken = alu_lsb ^ funct3[0];
      end
      3'b110, 3'b111: begin
        branch_op    = ALU_SLTU;
        branch_taken = alu_lsb ^ funct3[0];
      end
      default: branch_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= state_nxt;
  end

  // Outputs are gated by reset directly so an access in progress is
  // abandoned in the same cycle reset rises, not one edge later.
  always_comb begin
    state_nxt = state;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    addr_sel  = 1'b0;
    ir_we     = 1'b0;
    mdr_we    = 1'b0;
    pc_we     = 1'b0;
    pc_src    = 2'd0;
    aout_we   = 1'b0;
    alu_op    = ALU_NOP;
    alu_src_a = 2'd0;
    alu_src_b = 1'b0;
    rf_we     = 1'b0;
    wb_sel    = 2'd0;
    trap      = 1'b0;
    if (!reset) begin
      case (state)
        FETCH: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_we     = 1'b1;
            state_nxt = DECODE;
          end
        end
        DECODE: begin
          // Speculatively compute PC + imm for branch/JAL targets.
          alu_src_a = 2'd1;
          alu_src_b = 1'b1;
          alu_op    = ALU_ADD;
          aout_we   = 1'b1;
          state_nxt = opc_legal ? EXECUTE : TRAP;
        end
        EXECUTE: begin
          case (opcode)
            OPC_OP, OPC_OPIMM: begin
              alu_src_a = 2'd0;
              alu_src_b = (opcode == OPC_OPIMM);
              alu_op    = arith_op;
              aout_we   = 1'b1;
              state_nxt = WB;
            end
            OPC_LUI: begin
              alu_src_a = 2'd2;
              alu_src_b = 1'b1;
              alu_op    = ALU_ADD;
              aout_we   = 1'b1;
              state_nxt = WB;
            end
            OPC_AUIPC: begin
              alu_src_a = 2'd1;
              alu_src_b = 1'b1;
              alu_op    = ALU_ADD;
              aout_we   = 1'b1;
              state_nxt = WB;
            end
            OPC_LOAD, OPC_STORE: begin
              alu_src_a = 2'd0;
              alu_src_b = 1'b1;
              alu_op    = ALU_ADD;
              aout_we   = 1'b1;
              state_nxt = MEM;
            end
            OPC_BRANCH: begin
              if (branch_ok) begin
                alu_src_a = 2'd0;
                alu_src_b = 1'b0;
                alu_op    = branch_op;
                pc_we     = 1'b1;
                pc_src    = branch_taken ? 2'd1 : 2'd0;
                state_nxt = FETCH;
              end else begin
                state_nxt = TRAP;
              end
            end
            OPC_JAL: begin
              rf_we     = 1'b1;
              wb_sel    = 2'd2;
              pc_we     = 1'b1;
              pc_src    = 2'd1;
              state_nxt = FETCH;
            end
            OPC_JALR: begin
              alu_src_a = 2'd0;
              alu_src_b = 1'b1;
              alu_op    = ALU_ADD;
              rf_we     = 1'b1;
              wb_sel    = 2'd2;
              pc_we     = 1'b1;
              pc_src    = 2'd2;
              state_nxt = FETCH;
            end
            default: state_nxt = TRAP;
          endcase
        end
        MEM: begin
          mem_req  = 1'b1;
          addr_sel = 1'b1;
          mem_we   = is_store;
          if (mem_ready) begin
            if (is_store) begin
              pc_we     = 1'b1;
              pc_src    = 2'd0;
              state_nxt = FETCH;
            end else begin
              mdr_we    = 1'b1;
              state_nxt = WB;
            end
          end
        end
        WB: begin
          rf_we     = 1'b1;
          wb_sel    = is_load ? 2'd1 : 2'd0;
          pc_we     = 1'b1;
          pc_src    = 2'd0;
          state_nxt = FETCH;
        end
        TRAP: begin
          trap = 1'b1;
        end
        default: state_nxt = FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control
//   Directed-vector bench for multicycle_control. Inputs change 2 time
//   units after the rising edge; outputs are checked 1 unit later.
module tb_multicycle_control;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_NOP  = 4'd15;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic        alu_zero;
  logic        alu_lsb;
  logic        mem_ready;
  logic        mem_req;
  logic        mem_we;
  logic        addr_sel;
  logic        ir_we;
  logic        mdr_we;
  logic        pc_we;
  logic [1:0]  pc_src;
  logic        aout_we;
  logic [3:0]  alu_op;
  logic [1:0]  alu_src_a;
  logic        alu_src_b;
  logic        rf_we;
  logic [1:0]  wb_sel;
  logic        trap;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  multicycle_control dut (
    .clk       (clk),
    .reset     (reset),
    .instr     (instr),
    .alu_zero  (alu_zero),
    .alu_lsb   (alu_lsb),
    .mem_ready (mem_ready),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .addr_sel  (addr_sel),
    .ir_we     (ir_we),
    .mdr_we    (mdr_we),
    .pc_we     (pc_we),
    .pc_src    (pc_src),
    .aout_we   (aout_we),
    .alu_op    (alu_op),
    .alu_src_a (alu_src_a),
    .alu_src_b (alu_src_b),
    .rf_we     (rf_we),
    .wb_sel    (wb_sel),
    .trap      (trap)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  // From FETCH with mem_ready=1: FETCH, DECODE, ends in EXECUTE.
  task automatic to_execute(input logic [31:0] i);
    instr     = i;
    mem_ready = 1'b1;
    settle();
    check("fetch_req", {31'd0, mem_req}, 32'd1);
    check("fetch_irwe", {31'd0, ir_we}, 32'd1);
    tick();
    check("dec_aout", {31'd0, aout_we}, 32'd1);
    tick();
  endtask

  initial begin
    reset     = 1'b1;
    instr     = 32'h0000_0013;
    alu_zero  = 1'b0;
    alu_lsb   = 1'b0;
    mem_ready = 1'b1;
    settle();
    check("rst_memreq", {31'd0, mem_req}, 32'd0);
    check("rst_irwe", {31'd0, ir_we}, 32'd0);
    check("rst_trap", {31'd0, trap}, 32'd0);
    check("rst_aluop", {28'd0, alu_op}, {28'd0, ALU_NOP});
    tick();
    tick();
    reset = 1'b0;
    settle();

    // ADDI x1,x0,5
    instr = 32'h0050_0093;
    settle();
    check("addi_f_req", {31'd0, mem_req}, 32'd1);
    check("addi_f_addr", {31'd0, addr_sel}, 32'd0);
    check("addi_f_irwe", {31'd0, ir_we}, 32'd1);
    check("addi_f_pcwe", {31'd0, pc_we}, 32'd0);
    tick();
    check("addi_d_op", {28'd0, alu_op}, {28'd0, ALU_ADD});
    check("addi_d_srca", {30'd0, alu_src_a}, 32'd1);
    check("addi_d_srcb", {31'd0, alu_src_b}, 32'd1);
    check("addi_d_pcwe", {31'd0, pc_we}, 32'd0);
    tick();
    check("addi_e_op", {28'd0, alu_op}, {28'd0, ALU_ADD});
    check("addi_e_srca", {30'd0, alu_src_a}, 32'd0);
    check("addi_e_srcb", {31'd0, alu_src_b}, 32'd1);
    check("addi_e_aout", {31'd0, aout_we}, 32'd1);
    check("addi_e_rfwe", {31'd0, rf_we}, 32'd0);
    tick();
    check("addi_wb_rfwe", {31'd0, rf_we}, 32'd1);
    check("addi_wb_sel", {30'd0, wb_sel}, 32'd0);
    check("addi_wb_pcwe", {31'd0, pc_we}, 32'd1);
    check("addi_wb_pcsrc", {30'd0, pc_src}, 32'd0);
    tick();

    // BEQ x1,x2,8 : taken then not-taken in the same EXECUTE cycle
    to_execute(32'h0020_8463);
    alu_zero = 1'b1;
    settle();
    check("beq_op", {28'd0, alu_op}, {28'd0, ALU_SUB});
    check("beq_t_pcwe", {31'd0, pc_we}, 32'd1);
    check("beq_t_pcsrc", {30'd0, pc_src}, 32'd1);
    check("beq_aout", {31'd0, aout_we}, 32'd0);
    alu_zero = 1'b0;
    settle();
    check("beq_nt_pcsrc", {30'd0, pc_src}, 32'd0);
    check("beq_nt_pcwe", {31'd0, pc_we}, 32'd1);
    tick();

    // BGE x1,x2,8 with SLT result 1 -> not taken
    to_execute(32'h0020_D463);
    alu_lsb = 1'b1;
    settle();
    check("bge_op", {28'd0, alu_op}, {28'd0, ALU_SLT});
    check("bge_pcsrc", {30'd0, pc_src}, 32'd0);
    alu_lsb = 1'b0;
    settle();
    check("bge_t_pcsrc", {30'd0, pc_src}, 32'd1);
    tick();
    check("bge_back_fetch", {31'd0, mem_req}, 32'd1);

    // LW x1,0(x1) with three wait cycles in MEM
    to_execute(32'h0000_A083);
    check("lw_e_op", {28'd0, alu_op}, {28'd0, ALU_ADD});
    check("lw_e_srcb", {31'd0, alu_src_b}, 32'd1);
    tick();
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("lw_wait_req", {31'd0, mem_req}, 32'd1);
      check("lw_wait_addr", {31'd0, addr_sel}, 32'd1);
      check("lw_wait_mdr", {31'd0, mdr_we}, 32'd0);
      tick();
    end
    mem_ready = 1'b1;
    settle();
    check("lw_rdy_mdr", {31'd0, mdr_we}, 32'd1);
    check("lw_rdy_we", {31'd0, mem_we}, 32'd0);
    tick();
    check("lw_wb_sel", {30'd0, wb_sel}, 32'd1);
    check("lw_wb_rfwe", {31'd0, rf_we}, 32'd1);
    tick();

    // SW x2,0(x1)
    to_execute(32'h0020_A023);
    tick();
    check("sw_mem_we", {31'd0, mem_we}, 32'd1);
    check("sw_pcwe", {31'd0, pc_we}, 32'd1);
    check("sw_mdr", {31'd0, mdr_we}, 32'd0);
    tick();
    check("sw_back_fetch", {31'd0, mem_req}, 32'd1);

    // ALU op decode
    to_execute(32'h4020_8033);
    check("sub_op", {28'd0, alu_op}, {28'd0, ALU_SUB});
    check("sub_srcb", {31'd0, alu_src_b}, 32'd0);
    tick(); tick();
    to_execute(32'h4020_D033);
    check("sra_op", {28'd0, alu_op}, {28'd0, ALU_SRA});
    tick(); tick();
    to_execute(32'h0020_D093);
    check("srli_op", {28'd0, alu_op}, {28'd0, ALU_SRL});
    check("srli_srcb", {31'd0, alu_src_b}, 32'd1);
    tick(); tick();

    // JAL x1,8 and JALR x1,0(x2)
    to_execute(32'h0080_00EF);
    check("jal_pcsrc", {30'd0, pc_src}, 32'd1);
    check("jal_wbsel", {30'd0, wb_sel}, 32'd2);
    check("jal_rfwe", {31'd0, rf_we}, 32'd1);
    tick();
    to_execute(32'h0001_00E7);
    check("jalr_pcsrc", {30'd0, pc_src}, 32'd2);
    check("jalr_op", {28'd0, alu_op}, {28'd0, ALU_ADD});
    tick();
    check("jalr_back_fetch", {31'd0, mem_req}, 32'd1);

    // Undefined branch funct3=010 -> TRAP without PC write
    to_execute(32'h0020_A063);
    check("badbr_pcwe", {31'd0, pc_we}, 32'd0);
    tick();
    check("badbr_trap", {31'd0, trap}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    settle();

    // Illegal opcode 0x7F -> sticky TRAP
    to_execute(32'h0000_007F);
    for (int i = 0; i < 3; i++) begin
      check("ill_trap", {31'd0, trap}, 32'd1);
      check("ill_pcwe", {31'd0, pc_we}, 32'd0);
      check("ill_rfwe", {31'd0, rf_we}, 32'd0);
      check("ill_req", {31'd0, mem_req}, 32'd0);
      tick();
    end
    reset = 1'b1;
    settle();
    check("ill_rst_trap", {31'd0, trap}, 32'd0);
    tick();
    reset = 1'b0;
    settle();

    // ECALL -> TRAP
    to_execute(32'h0000_0073);
    check("ecall_trap", {31'd0, trap}, 32'd1);
    tick();
    check("ecall_sticky", {31'd0, trap}, 32'd1);

    // Reset while FETCH waits on memory
    reset = 1'b1;
    tick();
    reset     = 1'b0;
    mem_ready = 1'b0;
    settle();
    check("fw_trap_clr", {31'd0, trap}, 32'd0);
    check("fw_req", {31'd0, mem_req}, 32'd1);
    check("fw_irwe", {31'd0, ir_we}, 32'd0);
    tick();
    reset = 1'b1;
    settle();
    check("fw_rst_req", {31'd0, mem_req}, 32'd0);
    tick();
    reset     = 1'b0;
    mem_ready = 1'b1;
    instr     = 32'h0050_0093;
    settle();
    check("fw_after_req", {31'd0, mem_req}, 32'd1);
    check("fw_after_irwe", {31'd0, ir_we}, 32'd1);
    tick();
    check("fw_after_dec", {31'd0, aout_we}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
